// File: rtl/i2c_raw_tx.sv
// Write-only I2C master that drives raw SCL/SDA: START, address+W, bytes taken over a
// valid/ready stream, per-byte ACK sampling, STOP. Define I2C_RAW_TX_NACK_ABORT_EN to end the transfer on NACK.
module i2c_raw_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_ADDR     = 3'd2,
    ST_ADDR_ACK = 3'd3,
    ST_LOAD     = 3'd4,
    ST_DATA     = 3'd5,
    ST_DATA_ACK = 3'd6,
    ST_STOP     = 3'd7
  } state_t;

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
`ifdef I2C_RAW_TX_NACK_ABORT_EN
  localparam logic ABORT_EN = 1'b1;
`else
  localparam logic ABORT_EN = 1'b0;
`endif

  state_t     state_r, state_s;
  logic [7:0] div_r, div_s;
  logic [1:0] q_r, q_s;
  logic [2:0] bit_r, bit_s;
  logic [7:0] shift_r, shift_s;
  logic       last_r, last_s;
  logic       nacked_r, nacked_s;
  logic       done_s, nack_s;
  logic       tick_s, end_s;

  // Line levels {scl, sda} for a given state and quarter; outputs are registered from the next state,
  // so the pins line up with the state that is current on the following cycle.
  function automatic logic [1:0] drive(input state_t st, input logic [1:0] q, input logic msb);
    logic [1:0] v;
    case (st)
      ST_IDLE:                  v = 2'b11;
      ST_START:                 v = (q[1] == 1'b0) ? 2'b11 : 2'b10;
      ST_ADDR, ST_DATA:         v = {q[1], msb};
      ST_ADDR_ACK, ST_DATA_ACK: v = {q[1], 1'b1};
      ST_LOAD:                  v = 2'b00;
      ST_STOP:                  v = (q == 2'd0) ? 2'b00 : ((q == 2'd1) ? 2'b10 : 2'b11);
      default:                  v = 2'b11;
    endcase
    return v;
  endfunction

  assign tick_s = (div_r == DIV_MAX);
  assign end_s  = tick_s && (q_r == 2'd3);

  // Next-state, divider/quarter, shift register and pulse decode
  always_comb begin
    state_s  = state_r;
    div_s    = div_r;
    q_s      = q_r;
    bit_s    = bit_r;
    shift_s  = shift_r;
    last_s   = last_r;
    nacked_s = nacked_r;
    done_s   = 1'b0;
    nack_s   = 1'b0;

    // The bit clock only runs while a timed state is active
    if ((state_r == ST_IDLE) || (state_r == ST_LOAD)) begin
      div_s = 8'd0;
      q_s   = 2'd0;
    end else if (tick_s) begin
      div_s = 8'd0;
      q_s   = q_r + 2'd1;
    end else begin
      div_s = div_r + 8'd1;
    end

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          shift_s  = {addr, 1'b0};
          bit_s    = 3'd7;
          nacked_s = 1'b0;
          state_s  = ST_START;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_START: begin
        if (end_s) begin
          bit_s   = 3'd7;
          state_s = ST_ADDR;
        end else begin
          state_s = ST_START;
        end
      end
      ST_ADDR, ST_DATA: begin
        if (end_s && (bit_r == 3'd0)) begin
          nacked_s = 1'b0;
          state_s  = (state_r == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
        end else if (end_s) begin
          bit_s   = bit_r - 3'd1;
          shift_s = {shift_r[6:0], 1'b0};
        end else begin
          state_s = state_r;
        end
      end
      ST_ADDR_ACK, ST_DATA_ACK: begin
        // sda_i is taken on the last cycle of q2, while SCL is high
        if (tick_s && (q_r == 2'd2)) begin
          nacked_s = sda_i;
          nack_s   = sda_i;
        end else if (end_s) begin
          if ((ABORT_EN && nacked_r) || ((state_r == ST_DATA_ACK) && last_r)) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (tx_valid && tx_ready) begin
          shift_s = tx_data;
          last_s  = tx_last;
          bit_s   = 3'd7;
          state_s = ST_DATA;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_STOP: begin
        if (end_s) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      div_r    <= 8'd0;
      q_r      <= 2'd0;
      bit_r    <= 3'd0;
      shift_r  <= 8'd0;
      last_r   <= 1'b0;
      nacked_r <= 1'b0;
      scl_o    <= 1'b1;
      sda_o    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      state_r        <= state_s;
      div_r          <= div_s;
      q_r            <= q_s;
      bit_r          <= bit_s;
      shift_r        <= shift_s;
      last_r         <= last_s;
      nacked_r       <= nacked_s;
      {scl_o, sda_o} <= drive(state_s, q_s, shift_s[7]);
      busy           <= (state_s != ST_IDLE);
      done           <= done_s;
      nack           <= nack_s;
      tx_ready       <= (state_s == ST_LOAD);
    end
  end

endmodule

// File: tb/tb_i2c_raw_tx.sv
// Directed bench for i2c_raw_tx: records SDA on every SCL rising edge and compares against
// hand-written bit strings, plus STOP/done/nack/handshake counts.
module tb_i2c_raw_tx;
  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic reset, start, tx_valid, tx_last, sda_i;
  logic [6:0] addr;
  logic [7:0] tx_data;
  logic tx_ready, scl_o, sda_o, busy, done, nack;

  i2c_raw_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready), .sda_i(sda_i),
    .scl_o(scl_o), .sda_o(sda_o), .busy(busy), .done(done), .nack(nack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic tmo;
  int stall_bad;
  logic [7:0] bytes [4];

  // Bus monitor
  logic mon_clr = 1'b0;
  logic [63:0] obs_bits;
  int obs_n, done_cnt, nack_cnt, stop_cnt, hs_cnt, cyc, rise1, rise2;
  logic prev_scl, prev_sda;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_scl <= scl_o;
    prev_sda <= sda_o;
    if (mon_clr) begin
      obs_bits <= 64'd0; obs_n <= 0; done_cnt <= 0; nack_cnt <= 0; stop_cnt <= 0;
      rise1 <= 0; rise2 <= 0;
    end else begin
      if (scl_o && !prev_scl) begin
        obs_bits <= {obs_bits[62:0], sda_o};
        obs_n    <= obs_n + 1;
        if (obs_n == 0) rise1 <= cyc;
        if (obs_n == 1) rise2 <= cyc;
      end
      if (scl_o && prev_scl && sda_o && !prev_sda) stop_cnt <= stop_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (nack) nack_cnt <= nack_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (mon_clr) hs_cnt <= 0;
    else if (tx_valid && tx_ready && !reset) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    cyc = 0;
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic mon_clear();
    mon_clr = 1'b1;
    repeat (2) @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic run_txn(input logic [6:0] a, input int nbytes, input int stall, input int glitch);
    int w;
    tmo = 1'b0;
    stall_bad = 0;
    mon_clear();
    addr = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (glitch > 0) begin
      repeat (glitch) @(negedge clk);
      addr = 7'h7F; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < nbytes; i++) begin
      w = 0;
      while (!tx_ready && done_cnt == 0 && w < 3000) begin @(negedge clk); w++; end
      if (w >= 3000) tmo = 1'b1;
      if (done_cnt != 0 || tmo) break;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (scl_o !== 1'b0) stall_bad++;
      end
      tx_data = bytes[i]; tx_last = (i == nbytes - 1); tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
    w = 0;
    while (done_cnt == 0 && w < 3000) begin @(negedge clk); w++; end
    if (w >= 3000) tmo = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; addr = 7'd0; tx_valid = 1'b0; tx_data = 8'd0;
    tx_last = 1'b0; sda_i = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (scl_o !== 1'b1) begin bad++; $display("FAIL rst_scl: got %b want 1", scl_o); end
    total++; if (sda_o !== 1'b1) begin bad++; $display("FAIL rst_sda: got %b want 1", sda_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (nack !== 1'b0) begin bad++; $display("FAIL rst_nack: got %b want 0", nack); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", tx_ready); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bytes[0] = 8'hA5;
    run_txn(7'h50, 1, 0, 0);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL basic_timeout: got %b want 0", tmo); end
    total++; if (obs_n != 19) begin bad++; $display("FAIL basic_nbits: got %0d want 19", obs_n); end
    total++; if (obs_bits[18:0] !== 19'b1010000011010010110) begin bad++; $display("FAIL basic_bits: got %b want 1010000011010010110", obs_bits[18:0]); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
    total++; if (nack_cnt != 0) begin bad++; $display("FAIL basic_nack: got %0d want 0", nack_cnt); end
    total++; if (stop_cnt != 1) begin bad++; $display("FAIL basic_stop: got %0d want 1", stop_cnt); end
    total++; if (hs_cnt != 1) begin bad++; $display("FAIL basic_hs: got %0d want 1", hs_cnt); end
    total++; if (rise2 - rise1 != 4 * CLK_DIV) begin bad++; $display("FAIL basic_period: got %0d want %0d", rise2 - rise1, 4 * CLK_DIV); end
    total++; if ({busy, scl_o, sda_o} !== 3'b011) begin bad++; $display("FAIL basic_idle: got %b want 011", {busy, scl_o, sda_o}); end
  endtask

  task automatic test_stall();
    bytes[0] = 8'hA5;
    run_txn(7'h50, 1, 40, 0);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL stall_timeout: got %b want 0", tmo); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_scl: got %0d high cycles want 0", stall_bad); end
    total++; if (obs_bits[18:0] !== 19'b1010000011010010110 || obs_n != 19) begin bad++; $display("FAIL stall_bits: got %b (%0d) want 1010000011010010110 (19)", obs_bits[18:0], obs_n); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_multi();
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
    run_txn(7'h3C, 3, 0, 0);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL multi_timeout: got %b want 0", tmo); end
    total++; if (hs_cnt != 3) begin bad++; $display("FAIL multi_hs: got %0d want 3", hs_cnt); end
    total++; if (stop_cnt != 1) begin bad++; $display("FAIL multi_stop: got %0d want 1", stop_cnt); end
    total++; if (obs_n != 37) begin bad++; $display("FAIL multi_nbits: got %0d want 37", obs_n); end
    total++; if (obs_bits[36:0] !== 37'b0111100010000000110000001010000001110) begin bad++; $display("FAIL multi_bits: got %b want 0111100010000000110000001010000001110", obs_bits[36:0]); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL multi_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_nack();
    sda_i = 1'b1;
    bytes[0] = 8'hA5;
    run_txn(7'h50, 1, 0, 0);
    sda_i = 1'b0;
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL nack_timeout: got %b want 0", tmo); end
`ifdef I2C_RAW_TX_NACK_ABORT_EN
    total++; if (nack_cnt != 1) begin bad++; $display("FAIL nack_count: got %0d want 1", nack_cnt); end
    total++; if (hs_cnt != 0) begin bad++; $display("FAIL nack_hs: got %0d want 0", hs_cnt); end
    total++; if (obs_bits[9:0] !== 10'b1010000010 || obs_n != 10) begin bad++; $display("FAIL nack_bits: got %b (%0d) want 1010000010 (10)", obs_bits[9:0], obs_n); end
`else
    total++; if (nack_cnt != 2) begin bad++; $display("FAIL nack_count: got %0d want 2", nack_cnt); end
    total++; if (hs_cnt != 1) begin bad++; $display("FAIL nack_hs: got %0d want 1", hs_cnt); end
    total++; if (obs_bits[18:0] !== 19'b1010000011010010110 || obs_n != 19) begin bad++; $display("FAIL nack_bits: got %b (%0d) want 1010000011010010110 (19)", obs_bits[18:0], obs_n); end
`endif
    total++; if (stop_cnt != 1) begin bad++; $display("FAIL nack_stop: got %0d want 1", stop_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL nack_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int w;
    mon_clear();
    addr = 7'h50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!tx_ready && w < 3000) begin @(negedge clk); w++; end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", tx_ready); end
    tx_data = 8'hA5; tx_last = 1'b1; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    // 64..79 cycles into DATA is bit 3
    repeat (65) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if ({scl_o, sda_o, busy} !== 3'b110) begin bad++; $display("FAIL rmid_lines: got scl/sda/busy=%b want 110", {scl_o, sda_o, busy}); end
    reset = 1'b0;
    @(negedge clk);
    bytes[0] = 8'hA5;
    run_txn(7'h50, 1, 0, 0);
    total++; if (obs_bits[18:0] !== 19'b1010000011010010110 || obs_n != 19) begin bad++; $display("FAIL rmid_bits: got %b (%0d) want 1010000011010010110 (19)", obs_bits[18:0], obs_n); end
    total++; if (done_cnt != 1 || tmo) begin bad++; $display("FAIL rmid_done: got %0d tmo=%b want 1 tmo=0", done_cnt, tmo); end
  endtask

  task automatic test_start_busy();
    bytes[0] = 8'hA5;
    run_txn(7'h50, 1, 0, 20);
    total++; if (obs_bits[18:0] !== 19'b1010000011010010110 || obs_n != 19) begin bad++; $display("FAIL busy_bits: got %b (%0d) want 1010000011010010110 (19)", obs_bits[18:0], obs_n); end
    total++; if (done_cnt != 1 || tmo) begin bad++; $display("FAIL busy_done: got %0d tmo=%b want 1 tmo=0", done_cnt, tmo); end
    total++; if (stop_cnt != 1) begin bad++; $display("FAIL busy_stop: got %0d want 1", stop_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_multi();
    test_nack();
    test_reset_mid();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_raw_tx.md
I2C_RAW_TX -- requirements
Module: i2c_raw_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per SCL quarter-period; legal range 2..255.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle request to begin a write transaction; sampled only in IDLE.
REQ-005 addr  in  7  target address; latched when start is accepted.
REQ-006 tx_valid  in  1  data byte available.
REQ-007 tx_data  in  8  data byte, sent MSB first.
REQ-008 tx_last  in  1  qualifies tx_data as the final byte of the transaction.
REQ-009 tx_ready  out  1  byte accepted on a cycle where tx_valid and tx_ready are both high.
REQ-010 sda_i  in  1  sampled SDA line level, used for ACK.
REQ-011 scl_o  out  1  SCL drive; 1 = release, 0 = pull low.
REQ-012 sda_o  out  1  SDA drive; 1 = release, 0 = pull low.
REQ-013 busy  out  1  high from start acceptance until the STOP completes.
REQ-014 done  out  1  one-cycle pulse when the STOP completes.
REQ-015 nack  out  1  one-cycle pulse when an ACK slot samples sda_i=1.

Function
REQ-016 A divider counts 0..CLK_DIV-1; a quarter-tick occurs when it equals CLK_DIV-1, and quarter index q advances 0..3 on each tick.
REQ-017 The state machine has states IDLE, START, ADDR, ADDR_ACK, LOAD, DATA, DATA_ACK and STOP; states other than IDLE and LOAD last 4 quarters per bit.
REQ-018 IDLE: scl_o=1, sda_o=1; start=1 latches {addr,1'b0} into the shift register, sets busy, clears the divider and q, and moves to START.
REQ-019 START: SDA/SCL per quarter are q0 1/1, q1 1/1, q2 0/1, q3 0/1; then ADDR.
REQ-020 Bit states ADDR and DATA: q0 SCL=0 with SDA=shift MSB; q1 SCL=0; q2 SCL=1; q3 SCL=1; shift left after q3; the bit counter runs 7..0, with the ACK state following after bit 0.
REQ-021 ACK states release SDA (sda_o=1) and use the same SCL quarters as bit states; sda_i is sampled on the last cycle of q2, and nack pulses on the following cycle if it is 1.
REQ-022 After ADDR_ACK, or after a DATA_ACK whose byte had tx_last=0: LOAD, holding scl_o=0 and sda_o=0, asserting tx_ready, and waiting indefinitely.
REQ-023 LOAD handshake: tx_valid=1 captures tx_data and tx_last, deasserts tx_ready on the next cycle, and moves to DATA at q0; tx_ready is 0 in all other states.
REQ-024 After a DATA_ACK whose byte had tx_last=1: STOP.
REQ-025 STOP: SDA/SCL per quarter are q0 0/0, q1 0/1, q2 1/1, q3 1/1; at the end of q3 pulse done for one cycle, clear busy, and go to IDLE.
REQ-026 start while busy=1 is ignored.
REQ-027 scl_o and sda_o are registered, and SDA changes only while SCL is low except in START and STOP.
REQ-028 Bit period = 4*CLK_DIV cycles.

Reset
REQ-029 reset=1 forces the IDLE state, scl_o=1, sda_o=1, busy=0, done=0, nack=0, tx_ready=0, with divider, q, bit counter and shift register all cleared, on the next edge.
REQ-030 reset mid-transaction abandons the bus without generating a STOP; reset takes precedence over a simultaneous start or handshake.

Configuration
REQ-031 Macro I2C_RAW_TX_NACK_ABORT_EN defined: a NACK in ADDR_ACK or DATA_ACK goes directly to STOP after q3, skipping LOAD.
REQ-032 Macro I2C_RAW_TX_NACK_ABORT_EN undefined: nack still pulses, but the transaction continues as if ACKed.

Verification
REQ-033 CLK_DIV=4, addr=0x50, one byte 0xA5 with tx_last=1, slave ACKs both slots -> SDA bit sequence 1010_0000 then 1010_0101 on SCL rising edges, STOP generated, done pulses once, nack never pulses.
REQ-034 Same transaction with tx_valid held low for 40 cycles in LOAD -> scl_o stays 0 for those 40 cycles, and no bit is lost.
REQ-035 Three bytes 0x01, 0x02, 0x03 with tx_last only on 0x03 -> exactly three tx_ready handshakes, and STOP only after the third ACK.
REQ-036 sda_i=1 in the ADDR_ACK slot -> nack pulses; with the macro, STOP follows immediately; without it, LOAD and data still occur.
REQ-037 reset asserted during DATA bit 3 -> the next cycle shows scl_o=1, sda_o=1, busy=0; a subsequent start runs a clean transaction.
REQ-038 start pulsed while busy -> ignored, and the addr change has no effect on the bits in flight.
